// File: rtl/esfa_pkg.sv
// Shared encodings for the ESFA cell controller: broadcast selectors,
// host command opcodes, response status codes and sequencer states.
package esfa_pkg;

    localparam logic [7:0] SEL_UPDATE       = 8'd0;
    localparam logic [7:0] SEL_LOOKUP       = 8'd1;
    localparam logic [7:0] SEL_ENCODE       = 8'd2;
    localparam logic [7:0] SEL_CONGRUE_UP   = 8'd3;
    localparam logic [7:0] SEL_CONGRUE_DOWN = 8'd4;
    localparam logic [7:0] SEL_FREE_QUERY   = 8'd5;
    localparam logic [7:0] SEL_ENRANK       = 8'd6;
    localparam logic [7:0] SEL_DEBUG        = 8'd7;
    localparam logic [7:0] SEL_NOP          = 8'd8;

    localparam logic [2:0] OP_UPDATE       = 3'd0;
    localparam logic [2:0] OP_LOOKUP       = 3'd1;
    localparam logic [2:0] OP_ENCODE       = 3'd2;
    localparam logic [2:0] OP_CONGRUE_UP   = 3'd3;
    localparam logic [2:0] OP_CONGRUE_DOWN = 3'd4;
    localparam logic [2:0] OP_FREE_QUERY   = 3'd5;
    localparam logic [2:0] OP_ENRANK       = 3'd6;
    localparam logic [2:0] OP_ILLEGAL      = 3'd7;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_ILLEGAL = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_NOP1, S_ISS1, S_CAP1, S_NOP2, S_ISS2, S_CAP2, S_RESP
    } state_t;

    // Commands needing a free cell first scan with markAvailable.
    function automatic logic [7:0] phase1_sel(input logic [2:0] op);
        if (op == OP_UPDATE || op == OP_CONGRUE_UP)
            return SEL_FREE_QUERY;
        return {5'd0, op};
    endfunction

endpackage

// File: rtl/esfa_prio_select.sv
// Lowest-index-wins reduction of the per-cell flag/result/context vectors.
module esfa_prio_select #(
    parameter int NUM_CELLS = 8,
    parameter int DATA_W    = 8
) (
    input  logic [NUM_CELLS-1:0]        cell_bool,
    input  logic [NUM_CELLS*DATA_W-1:0] result_vec,
    input  logic [NUM_CELLS*DATA_W-1:0] context_vec,
    output logic                        hit,
    output logic [DATA_W-1:0]           index,
    output logic [DATA_W-1:0]           value,
    output logic [DATA_W-1:0]           ctx
);

    always_comb begin
        hit   = |cell_bool;
        index = '0;
        value = '0;
        ctx   = '0;
        // Scan downwards so the lowest set index is the last to assign.
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (cell_bool[i]) begin
                index = DATA_W'(i);
                value = result_vec[i*DATA_W +: DATA_W];
                ctx   = context_vec[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/esfa_cell_controller.sv
// Sequencer owning the ESFA cell broadcast bus; one opcode at a time, NOP-separated.
// Optional ESFA_CTRL_STATS_EN adds saturating stat_cmds / stat_full counters.
module esfa_cell_controller
    import esfa_pkg::*;
#(
    parameter int NUM_CELLS = 8,
    parameter int DATA_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [DATA_W-1:0]           cmd_index,
    input  logic [DATA_W-1:0]           cmd_value,
    input  logic [DATA_W-1:0]           cmd_code,
    input  logic [DATA_W-1:0]           cmd_rank,
    input  logic [DATA_W-1:0]           cmd_handle,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [1:0]                  rsp_status,
    output logic                        rsp_hit,
    output logic [DATA_W-1:0]           rsp_handle,
    output logic [DATA_W-1:0]           rsp_value,
    output logic [DATA_W-1:0]           rsp_context,
    output logic [7:0]                  cell_selector,
    output logic [DATA_W-1:0]           cell_queried_handle,
    output logic [DATA_W-1:0]           cell_available_handle,
    output logic [DATA_W-1:0]           cell_inserted_index,
    output logic [DATA_W-1:0]           cell_inserted_value,
    output logic [DATA_W-1:0]           cell_given_code,
    output logic [DATA_W-1:0]           cell_given_rank,
    output logic                        cell_is_available_handle,
    output logic                        cell_is_given_code,
    output logic                        cell_is_given_rank,
    input  logic [NUM_CELLS-1:0]        cell_bool,
    input  logic [NUM_CELLS*DATA_W-1:0] cell_result_value,
    input  logic [NUM_CELLS*DATA_W-1:0] cell_context
`ifdef ESFA_CTRL_STATS_EN
    ,
    output logic [15:0]                 stat_cmds,
    output logic [15:0]                 stat_full
`endif
);

    state_t            state, state_nx;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] index_q, value_q, code_q, rank_q, handle_q, avail_q;
    logic [7:0]        sel_drv, sel_p1, sel_p2;
    logic              bus_act, phase2, two_phase, accept;
    logic              p_hit;
    logic [DATA_W-1:0] p_index, p_value, p_ctx;

    esfa_prio_select #(.NUM_CELLS(NUM_CELLS), .DATA_W(DATA_W)) u_prio (
        .cell_bool   (cell_bool),
        .result_vec  (cell_result_value),
        .context_vec (cell_context),
        .hit         (p_hit),
        .index       (p_index),
        .value       (p_value),
        .ctx         (p_ctx)
    );

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign two_phase = (op_q == OP_UPDATE) || (op_q == OP_CONGRUE_UP);
    assign sel_p1    = phase1_sel(op_q);
    assign sel_p2    = (op_q == OP_UPDATE) ? SEL_UPDATE : SEL_CONGRUE_UP;
    assign phase2    = (state == S_ISS2) || (state == S_CAP2);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // CAP repeats the ISS opcode so cells see no new selector edge.
    always_comb begin
        state_nx = state;
        sel_drv  = SEL_NOP;
        bus_act  = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid) state_nx = (cmd_op == OP_ILLEGAL) ? S_RESP : S_NOP1;
            S_NOP1: state_nx = S_ISS1;
            S_ISS1: begin
                sel_drv  = sel_p1;
                bus_act  = 1'b1;
                state_nx = S_CAP1;
            end
            S_CAP1: begin
                sel_drv  = sel_p1;
                bus_act  = 1'b1;
                state_nx = (two_phase && p_hit) ? S_NOP2 : S_RESP;
            end
            S_NOP2: state_nx = S_ISS2;
            S_ISS2: begin
                sel_drv  = sel_p2;
                bus_act  = 1'b1;
                state_nx = S_CAP2;
            end
            S_CAP2: begin
                sel_drv  = sel_p2;
                bus_act  = 1'b1;
                state_nx = S_RESP;
            end
            S_RESP: if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign cell_selector            = sel_drv;
    assign cell_is_given_code       = bus_act && (sel_drv == SEL_LOOKUP ||
                                                  sel_drv == SEL_CONGRUE_UP ||
                                                  sel_drv == SEL_CONGRUE_DOWN);
    assign cell_is_given_rank       = bus_act && (sel_drv == SEL_CONGRUE_UP);
    assign cell_is_available_handle = phase2;
    assign cell_available_handle    = phase2  ? avail_q  : '0;
    assign cell_queried_handle      = bus_act ? handle_q : '0;
    assign cell_inserted_index      = bus_act ? index_q  : '0;
    assign cell_inserted_value      = bus_act ? value_q  : '0;
    assign cell_given_code          = bus_act ? code_q   : '0;
    assign cell_given_rank          = bus_act ? rank_q   : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q        <= '0;
            index_q     <= '0;
            value_q     <= '0;
            code_q      <= '0;
            rank_q      <= '0;
            handle_q    <= '0;
            avail_q     <= '0;
            rsp_status  <= ST_OK;
            rsp_hit     <= 1'b0;
            rsp_handle  <= '0;
            rsp_value   <= '0;
            rsp_context <= '0;
        end else begin
            if (accept) begin
                op_q     <= cmd_op;
                index_q  <= cmd_index;
                value_q  <= cmd_value;
                code_q   <= cmd_code;
                rank_q   <= cmd_rank;
                handle_q <= cmd_handle;
                if (cmd_op == OP_ILLEGAL) begin
                    rsp_status  <= ST_ILLEGAL;
                    rsp_hit     <= 1'b0;
                    rsp_handle  <= '0;
                    rsp_value   <= '0;
                    rsp_context <= '0;
                end
            end
            // A two-phase hit here is overwritten by CAP2 before RESP.
            if (state == S_CAP1 || state == S_CAP2) begin
                rsp_status  <= (state == S_CAP1 && two_phase && !p_hit) ? ST_FULL : ST_OK;
                rsp_hit     <= p_hit;
                rsp_handle  <= p_index;
                rsp_value   <= p_value;
                rsp_context <= p_ctx;
            end
            if (state == S_CAP1)
                avail_q <= p_index;
        end
    end

`ifdef ESFA_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_cmds <= '0;
            stat_full <= '0;
        end else begin
            if (accept && stat_cmds != 16'hFFFF)
                stat_cmds <= stat_cmds + 16'd1;
            if (state == S_CAP1 && two_phase && !p_hit && stat_full != 16'hFFFF)
                stat_full <= stat_full + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_esfa_cell_controller.sv
// Bench for esfa_cell_controller: behavioural cell array on the bus plus an
// array-based reference of cell contents predicting every response.
module tb_esfa_cell_controller;

    localparam int NC = 8;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [DW-1:0]     cmd_index = '0, cmd_value = '0, cmd_code = '0, cmd_rank = '0, cmd_handle = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_status;
    logic              rsp_hit;
    logic [DW-1:0]     rsp_handle, rsp_value, rsp_context;
    logic [7:0]        cell_selector;
    logic [DW-1:0]     cell_queried_handle, cell_available_handle, cell_inserted_index;
    logic [DW-1:0]     cell_inserted_value, cell_given_code, cell_given_rank;
    logic              cell_is_available_handle, cell_is_given_code, cell_is_given_rank;
    logic [NC-1:0]     cell_bool;
    logic [NC*DW-1:0]  cell_result_value, cell_context;
`ifdef ESFA_CTRL_STATS_EN
    logic [15:0]       stat_cmds, stat_full;
`endif

    int vectors = 0;
    int miscompares = 0;

    esfa_cell_controller #(.NUM_CELLS(NC), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_index(cmd_index), .cmd_value(cmd_value), .cmd_code(cmd_code),
        .cmd_rank(cmd_rank), .cmd_handle(cmd_handle),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_hit(rsp_hit), .rsp_handle(rsp_handle), .rsp_value(rsp_value),
        .rsp_context(rsp_context),
        .cell_selector(cell_selector), .cell_queried_handle(cell_queried_handle),
        .cell_available_handle(cell_available_handle),
        .cell_inserted_index(cell_inserted_index), .cell_inserted_value(cell_inserted_value),
        .cell_given_code(cell_given_code), .cell_given_rank(cell_given_rank),
        .cell_is_available_handle(cell_is_available_handle),
        .cell_is_given_code(cell_is_given_code), .cell_is_given_rank(cell_is_given_rank),
        .cell_bool(cell_bool), .cell_result_value(cell_result_value),
        .cell_context(cell_context)
`ifdef ESFA_CTRL_STATS_EN
        , .stat_cmds(stat_cmds), .stat_full(stat_full)
`endif
    );

    always #5 clk = ~clk;

    // Cell matching rules shared by the bus-side cell array and the reference.
    function automatic logic cell_pred(input logic [7:0] sel, input int i, input logic occ,
                                       input logic [7:0] idx, lo, hi, index, code, qh,
                                       input logic gc);
        case (sel)
            8'd1:    return occ && idx == index && gc && code >= lo && code <= hi;
            8'd2:    return occ && idx == index;
            8'd4:    return occ && gc && code >= lo && code <= hi;
            8'd5:    return !occ;
            8'd6:    return occ && qh == 8'(i);
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural cell array: acts only on a change to a non-NOP selector.
    logic       c_occ  [NC];
    logic [7:0] c_idx  [NC], c_val [NC], c_lo [NC], c_hi [NC], c_rank [NC];
    logic [7:0] prev_sel;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                c_occ[i] <= 1'b0; c_idx[i] <= '0; c_val[i] <= '0;
                c_lo[i] <= '0; c_hi[i] <= '0; c_rank[i] <= '0;
            end
            cell_bool <= '0; cell_result_value <= '0; cell_context <= '0;
            prev_sel <= 8'd8;
        end else begin
            prev_sel <= cell_selector;
            if (cell_selector != prev_sel && cell_selector != 8'd8) begin
                for (int i = 0; i < NC; i++) begin
                    if ((cell_selector == 8'd0 ||
                         (cell_selector == 8'd3 && cell_is_given_code && cell_is_given_rank)) &&
                        cell_is_available_handle && cell_available_handle == 8'(i)) begin
                        c_occ[i]  <= 1'b1;
                        c_idx[i]  <= cell_inserted_index;
                        c_val[i]  <= cell_inserted_value;
                        c_lo[i]   <= (cell_selector == 8'd0) ? 8'h00 : (cell_given_code & 8'hF0);
                        c_hi[i]   <= (cell_selector == 8'd0) ? 8'hFF : (cell_given_code | 8'h0F);
                        c_rank[i] <= (cell_selector == 8'd0) ? 8'd1 : cell_given_rank;
                        cell_bool[i] <= 1'b1;
                        cell_result_value[i*DW +: DW] <= cell_inserted_value;
                        cell_context[i*DW +: DW] <= (cell_selector == 8'd0) ? 8'd1 : cell_given_rank;
                    end else begin
                        cell_bool[i] <= cell_pred(cell_selector, i, c_occ[i], c_idx[i], c_lo[i],
                                                  c_hi[i], cell_inserted_index, cell_given_code,
                                                  cell_queried_handle, cell_is_given_code);
                        cell_result_value[i*DW +: DW] <= c_val[i];
                        cell_context[i*DW +: DW] <= c_rank[i];
                    end
                end
            end
        end
    end

    // Reference contents of the cell array, updated per command.
    logic       r_occ  [NC];
    logic [7:0] r_idx  [NC], r_val [NC], r_lo [NC], r_hi [NC], r_rank [NC];

    task automatic ref_clear();
        for (int i = 0; i < NC; i++) begin
            r_occ[i] = 1'b0; r_idx[i] = '0; r_val[i] = '0;
            r_lo[i] = '0; r_hi[i] = '0; r_rank[i] = '0;
        end
    endtask

    function automatic logic [63:0] push(input logic [63:0] t, input logic [7:0] s);
        return {t[55:0], s};
    endfunction

    // Expected {status,hit,handle,value,context}, latency and selector trace.
    task automatic ref_cmd(input logic [2:0] op, input logic [7:0] ix, vl, cd, rk, hd,
                           output logic [26:0] er, output int el, output logic [63:0] et);
        int w = -1;
        er = '0;
        et = '0;
        el = 4;
        if (op == 3'd7) begin
            er = {2'd2, 25'd0};
            el = 1;
        end else if (op == 3'd0 || op == 3'd3) begin
            for (int i = NC - 1; i >= 0; i--) if (!r_occ[i]) w = i;
            et = push(push(push(et, 8'd8), 8'd5), 8'd5);
            if (w < 0) begin
                er = {2'd1, 25'd0};
            end else begin
                el = 7;
                et = push(push(push(et, 8'd8), {5'd0, op}), {5'd0, op});
                r_occ[w]  = 1'b1;
                r_idx[w]  = ix;
                r_val[w]  = vl;
                r_lo[w]   = (op == 3'd0) ? 8'h00 : (cd & 8'hF0);
                r_hi[w]   = (op == 3'd0) ? 8'hFF : (cd | 8'h0F);
                r_rank[w] = (op == 3'd0) ? 8'd1 : rk;
                er = {2'd0, 1'b1, 8'(w), vl, r_rank[w]};
            end
        end else begin
            et = push(push(push(et, 8'd8), {5'd0, op}), {5'd0, op});
            for (int i = NC - 1; i >= 0; i--)
                if (cell_pred({5'd0, op}, i, r_occ[i], r_idx[i], r_lo[i], r_hi[i], ix, cd, hd, 1'b1))
                    w = i;
            if (w >= 0) er = {2'd0, 1'b1, 8'(w), r_val[w], r_rank[w]};
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ctl", {cmd_ready, rsp_valid, rsp_status, rsp_hit, rsp_handle, rsp_value, rsp_context},
              {1'b1, 1'b0, 2'd0, 1'b0, 24'd0});
        check("reset_bus", {cell_selector, cell_queried_handle, cell_available_handle,
                            cell_inserted_index, cell_inserted_value, cell_given_code,
                            cell_given_rank, cell_is_available_handle, cell_is_given_code,
                            cell_is_given_rank}, {8'd8, 51'd0});
        reset = 1'b1;
        ref_clear();
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] ix, vl, cd, rk, hd,
                          input int hold);
        logic [26:0] er;
        logic [63:0] et, tr;
        int el, lat;
        ref_cmd(op, ix, vl, cd, rk, hd, er, el, et);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_index = ix; cmd_value = vl;
        cmd_code = cd; cmd_rank = rk; cmd_handle = hd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        tr = '0;
        while (!rsp_valid && lat < 20) begin
            tr = push(tr, cell_selector);
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(el));
        check("sel_trace", tr, et);
        check("rsp", {rsp_status, rsp_hit, rsp_handle, rsp_value, rsp_context}, er);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("rsp_hold", {rsp_valid, cmd_ready, cell_selector,
                               rsp_status, rsp_hit, rsp_handle, rsp_value, rsp_context},
                  {1'b1, 1'b0, 8'd8, er});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_release", {rsp_valid, cmd_ready, cell_selector}, {1'b0, 1'b1, 8'd8});
    endtask

    initial begin
        ref_clear();
        do_reset();

        // Directed: allocate, lookup in range, back-to-back repeat, illegal, stall.
        do_cmd(3'd0, 8'd3, 8'h55, 8'h00, 8'h00, 8'h00, 0);
        do_cmd(3'd1, 8'd3, 8'h00, 8'h40, 8'h00, 8'h00, 0);
        do_cmd(3'd1, 8'd3, 8'h00, 8'h40, 8'h00, 8'h00, 0);
        do_cmd(3'd7, 8'd3, 8'h11, 8'h22, 8'h33, 8'h44, 2);
        do_cmd(3'd1, 8'd9, 8'h00, 8'h40, 8'h00, 8'h00, 5);
        do_cmd(3'd3, 8'd4, 8'hA7, 8'h36, 8'h09, 8'h00, 1);
        do_cmd(3'd4, 8'd0, 8'h00, 8'h3C, 8'h00, 8'h00, 0);
        do_cmd(3'd6, 8'd0, 8'h00, 8'h00, 8'h00, 8'h01, 0);

        // Randomised mix; the array fills and later allocations report FULL.
        for (int n = 0; n < 60; n++)
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 8'($urandom),
                   8'($urandom), 8'($urandom), 8'($urandom_range(0, 9)),
                   int'($urandom_range(0, 3)));

        // Fill all cells, then both allocating ops must come back FULL.
        do_reset();
        for (int n = 0; n < NC; n++)
            do_cmd(3'd0, 8'(n), 8'($urandom), 8'h00, 8'h00, 8'h00, 0);
        do_cmd(3'd0, 8'd2, 8'h99, 8'h00, 8'h00, 8'h00, 0);
        do_cmd(3'd3, 8'd2, 8'h99, 8'h10, 8'h02, 8'h00, 0);
        do_cmd(3'd5, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0);

        // Reset asserted while phase 2 is on the bus drops the command.
        do_reset();
        do_cmd(3'd0, 8'd1, 8'h21, 8'h00, 8'h00, 8'h00, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_index = 8'd2; cmd_value = 8'h77;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("iss2_bus", {cell_selector, cell_is_available_handle, cell_available_handle},
              {8'd0, 1'b1, 8'd1});
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset", {cell_selector, rsp_valid, cmd_ready}, {8'd8, 1'b0, 1'b1});
        reset = 1'b1;
        ref_clear();
        do_cmd(3'd0, 8'd5, 8'h3E, 8'h00, 8'h00, 8'h00, 0);
        do_cmd(3'd2, 8'd5, 8'h00, 8'h00, 8'h00, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/esfa_cell_controller.md
# esfa_cell_controller

Sequencer that sits between a host command port and the array of ESFA memory cells. It owns the shared broadcast bus (selector plus operands) and drives one cell opcode at a time. It inserts the no-op selector before every opcode so each cell sees a selector change, then priority-reduces the per-cell result vectors into a single response. Commands that need a free cell (update, congrue-up) run as two phases: allocation scan, then the write.

## Interface
- NUM_CELLS, 8, number of cells on the bus; a cell's handle is its index, 0..NUM_CELLS-1.
- DATA_W, 8, width of handle, code, rank, index and value fields.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low; shared with the cells.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both are high.
- cmd_op  in  3  0 UPDATE, 1 LOOKUP, 2 ENCODE, 3 CONGRUE_UP, 4 CONGRUE_DOWN, 5 FREE_QUERY, 6 ENRANK, 7 illegal.
- cmd_index, cmd_value, cmd_code, cmd_rank, cmd_handle  in  DATA_W each  command operands.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_status  out  2  0 OK, 1 FULL, 2 ILLEGAL.
- rsp_hit  out  1  OR of cell_bool in the capture cycle.
- rsp_handle, rsp_value, rsp_context  out  DATA_W each  index, result value and context of the lowest-index cell with cell_bool set.
- cell_selector  out  8  broadcast opcode; 8 is the no-op.
- cell_queried_handle, cell_available_handle, cell_inserted_index, cell_inserted_value, cell_given_code, cell_given_rank  out  DATA_W each  broadcast operands.
- cell_is_available_handle, cell_is_given_code, cell_is_given_rank  out  1 each  operand-valid flags.
- cell_bool  in  NUM_CELLS  per-cell flag.
- cell_result_value, cell_context  in  NUM_CELLS*DATA_W each  cell i occupies bits [i*DATA_W +: DATA_W].

## Operation
- FSM states: IDLE, NOP1, ISS1, CAP1, NOP2, ISS2, CAP2, RESP.
- cmd_ready is 1 only in IDLE. On accept, all operands are latched.
- Phase-1 selector: the cmd_op value, except UPDATE and CONGRUE_UP, which use 5 (markAvailable).
- Illegal op (7): IDLE goes directly to RESP with status ILLEGAL and no bus activity.
- State behaviour:
  - NOP drives selector 8.
  - ISS drives the phase opcode.
  - CAP holds the same opcode, so cells do not re-execute, and registers the reduced result.
- Flag rules:
  - cell_is_given_code = 1 for opcodes 1, 3, 4.
  - cell_is_given_rank = 1 for opcode 3.
  - cell_is_available_handle = 1 only in phase 2.
  - All flags are 0 outside the ISS and CAP states.
- Operand mapping:
  - queried_handle ← cmd_handle; inserted_index ← cmd_index; inserted_value ← cmd_value; given_code ← cmd_code; given_rank ← cmd_rank.
  - available_handle ← the handle found in CAP1.
- After CAP1 for UPDATE or CONGRUE_UP:
  - No cell_bool set: go to RESP with status FULL; phase 2 is never issued.
  - Otherwise: NOP2, then ISS2 with opcode 0 or 3 respectively, then CAP2.
- RESP holds every rsp_* field stable until rsp_ready is high, then returns to IDLE.
- Priority reduction: lowest set index wins. rsp_handle is that index, zero-extended. No hit: handle, value and context are 0.

## Timing
- Cell outputs are valid in the cycle after the opcode first appears; the CAP state samples them.
- Latency from the accept edge to rsp_valid:
  - Single-phase: 4 cycles.
  - Two-phase: 7 cycles.
  - FULL: 4 cycles.
  - ILLEGAL: 1 cycle.
- Reset values: cmd_ready 1, rsp_valid 0, rsp_status 0, rsp_hit 0, all rsp data 0, cell_selector 8, all cell operands and flags 0.
- Reset asserted mid-command: returns to IDLE at that edge and the command is dropped. Cells reset on the same edge, so the array is cleared.
- cell_selector is 8 in IDLE and RESP. Back-to-back identical commands therefore always produce a selector change.

## Configuration
- ESFA_CTRL_STATS_EN defined: adds outputs stat_cmds[15:0] and stat_full[15:0].
  - stat_cmds counts accepted commands; stat_full counts FULL responses.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

## Structure
- esfa_pkg holds: selector constants SEL_UPDATE(0)..SEL_ENRANK(6), SEL_DEBUG(7), SEL_NOP(8); the cmd_op encodings; the rsp_status encodings; the FSM state enum.
- Sub-module esfa_prio_select: combinational, parameterised on NUM_CELLS and DATA_W. It takes cell_bool, result and context vectors and returns hit, index, value and context.

## Test plan
- Reset, then UPDATE index=3 value=0x55 → selector sequence 8,5,5,8,0,0; rsp_valid 7 cycles after accept; handle 0, status OK.
- Fill 8 cells, then UPDATE → status FULL at 4 cycles; selector never shows 0.
- LOOKUP index=3, code within the cell's low/high range → hit=1, value=0x55, context=1 (rank).
- Two back-to-back identical LOOKUPs → selector returns to 8 between them; both respond with hit=1.
- cmd_op=7 → ILLEGAL 1 cycle after accept; selector stays 8.
- rsp_ready held low 5 cycles → response stable and cmd_ready 0; reset pulsed during ISS2 → IDLE, selector 8, rsp_valid 0 on the next cycle.
